// File: rtl/mult16.sv
// mult16: sequential 16x16 shift-and-add multiplier, low 16 bits of product; MULT16_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are zero
module mult16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        ready,
  output logic        done,
  output logic [15:0] out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [15:0] mcand, mplier, acc, sum;
  logic [3:0] count;
  logic last;
  assign sum = acc + (mcand & {16{mplier[0]}});
`ifdef MULT16_EARLY_EXIT_EN
  assign last = count == 4'd15 || mplier[15:1] == 15'd0;
`else
  assign last = count == 4'd15;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      out    <= '0;
      ready  <= 1'b1;
      done   <= 1'b0;
    end else if (state == RUN) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 4'd1;
      if (last) begin
        out   <= sum;
        state <= DONE;
        ready <= 1'b1;
        done  <= 1'b1;
      end
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      count  <= '0;
      state  <= RUN;
      ready  <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= IDLE;
      done  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mult16.sv
// tb_mult16: scoreboard bench for mult16; expected products and done cycles queued at acceptance
module tb_mult16;
  logic clk = 0, reset = 1, start = 0;
  logic [15:0] a = 0, b = 0;
  logic ready, done;
  logic [15:0] out;
  typedef struct {logic [15:0] p; int t;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, end_c = 0;
  logic [15:0] mout = 0;

  mult16 dut (.clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ready(ready), .done(done), .out(out));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat(input logic [15:0] m);
`ifdef MULT16_EARLY_EXIT_EN
    int l = 1;
    for (int i = 0; i < 16; i++) if (m[i]) l = i + 1;
    return l;
`else
    return 16;
`endif
  endfunction

  // Single process: accept on rising edge, compare on falling edge
  always begin
    @(posedge clk);
    cyc++;
    if (!reset && start && cyc > end_c) begin
      end_c = cyc + lat(b);
      q.push_back('{p: 16'((32'(a) * 32'(b)) & 32'hffff), t: end_c});
    end
    @(negedge clk);
    if (reset) begin
      q.delete();
      end_c = 0;
      mout = 0;
    end else begin
      check("ready", 32'(ready), 32'(cyc >= end_c));
      if (q.size() > 0 && q[0].t == cyc) begin
        check("done", 32'(done), 1);
        check("out", 32'(out), 32'(q[0].p));
        mout = q[0].p;
        void'(q.pop_front());
      end else begin
        check("no_done", 32'(done), 0);
        check("hold", 32'(out), 32'(mout));
      end
    end
  end

  task automatic go(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk); #1;
    start = 1; a = x; b = y;
    @(negedge clk); #1;
    start = 0; a = $urandom; b = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk); #1;
    check("drain", q.size(), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(ready), 1);
    check("rst_done", 32'(done), 0);
    check("rst_out", 32'(out), 0);
    reset = 0;
    go(16'd3, 16'd5); drain();
    go(16'hffff, 16'hffff); drain();
    go(16'h0100, 16'h0100); drain();
    go(16'h0000, 16'h1234); drain();
    go(16'h1234, 16'h0000); drain();
    go(16'h00ab, 16'h0001); drain();
    go(16'h00ab, 16'h8000); drain();
    for (int i = 0; i < 4; i++) begin
      go(16'($urandom), 16'($urandom)); drain();
    end
    // start held through RUN: second op taken only in DONE
    @(negedge clk); #1;
    start = 1; a = 16'd2; b = 16'd3;
    @(negedge clk); #1;
    a = 16'd7; b = 16'd2;
    repeat (17) @(negedge clk);
    #1;
    start = 0;
    drain();
    // reset mid-RUN aborts with no done
    go(16'h1234, 16'h0002);
    repeat (7) @(negedge clk);
    #2;
    reset = 1;
    #1;
    check("abort_out", 32'(out), 0);
    check("abort_ready", 32'(ready), 1);
    check("abort_done", 32'(done), 0);
    @(negedge clk); #2;
    reset = 0;
    go(16'h1234, 16'h0002); drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
